// File: rtl/spi_reg_bridge_pkg.sv
// spi_reg_bridge_pkg: command byte layout, byte width and FSM state type for the SPI register bridge
package spi_reg_bridge_pkg;

    localparam int SPI_DATA_W   = 8;
    localparam int CMD_RW_BIT   = 7;
    localparam int CMD_ADDR_MSB = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WR_DATA,
        ST_RD_ISSUE,
        ST_RD_CAPTURE,
        ST_RD_DATA
    } state_e;

    function automatic logic cmd_is_read(input logic [SPI_DATA_W-1:0] cmd);
        return cmd[CMD_RW_BIT];
    endfunction

endpackage

// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: turns framed SPI bytes ({rw, addr} command then data/dummy bytes) into register-bank accesses
//
// Ports
//   in_clk, in_rst        clock, asynchronous active-high reset
//   in_cs_active          SPI frame active level (already synchronised)
//   in_rx_valid/_byte     one-cycle strobe with a received byte
//   o_tx_byte/_valid      read data handed back for the next MISO byte
//   o_reg_addr/_wdata     register address and write data
//   o_reg_we/_re          one-cycle write / read strobes (read data arrives one cycle after o_reg_re)
//   in_reg_rdata          register read data
//   o_err                 sticky overrun flag, cleared when the next frame starts
module spi_reg_bridge
    import spi_reg_bridge_pkg::*;
#(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = SPI_DATA_W,
    parameter bit AUTO_INC = 1'b1
) (
    input  logic              in_clk,
    input  logic              in_rst,
    input  logic              in_cs_active,
    input  logic              in_rx_valid,
    input  logic [DATA_W-1:0] in_rx_byte,
    output logic [DATA_W-1:0] o_tx_byte,
    output logic              o_tx_valid,
    output logic [ADDR_W-1:0] o_reg_addr,
    output logic [DATA_W-1:0] o_reg_wdata,
    output logic              o_reg_we,
    output logic              o_reg_re,
    input  logic [DATA_W-1:0] in_reg_rdata,
    output logic              o_err
);

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q, addr_inc_d, reg_addr_q;
    logic [DATA_W-1:0]   wdata_q, tx_byte_q;
    logic                we_q, re_q, tx_valid_q, err_q;
    // Set once CS has been seen low; keeps a frame already in progress at reset release from being decoded.
    logic                armed_q;

    assign addr_inc_d = AUTO_INC ? addr_q + ADDR_W'(1) : addr_q;

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            reg_addr_q <= '0;
            wdata_q    <= '0;
            tx_byte_q  <= '0;
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            tx_valid_q <= 1'b0;
            err_q      <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            we_q    <= 1'b0;
            armed_q <= armed_q | ~in_cs_active;
            if (!in_cs_active) begin
                // Frame end wins over any coincident byte; tx_byte is left as-is.
                state_q    <= ST_IDLE;
                re_q       <= 1'b0;
                tx_valid_q <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (armed_q) begin
                            state_q    <= ST_CMD;
                            err_q      <= 1'b0;
                            tx_valid_q <= 1'b0;
                        end
                    end
                    ST_CMD: begin
                        if (in_rx_valid) begin
                            addr_q  <= ADDR_W'(in_rx_byte[CMD_ADDR_MSB:0]);
                            state_q <= cmd_is_read(in_rx_byte) ? ST_RD_ISSUE : ST_WR_DATA;
                        end
                    end
                    ST_WR_DATA: begin
                        if (in_rx_valid) begin
                            we_q       <= 1'b1;
                            reg_addr_q <= addr_q;
                            wdata_q    <= in_rx_byte;
                            addr_q     <= addr_inc_d;
                        end
                    end
                    ST_RD_ISSUE: begin
                        if (in_rx_valid) err_q <= 1'b1;
                        re_q       <= 1'b1;
                        reg_addr_q <= addr_q;
                        state_q    <= ST_RD_CAPTURE;
                    end
                    ST_RD_CAPTURE: begin
                        if (in_rx_valid) err_q <= 1'b1;
                        // First cycle here is the strobe cycle; the register answers on the cycle after.
                        if (re_q) begin
                            re_q <= 1'b0;
                        end else begin
                            tx_byte_q  <= in_reg_rdata;
                            tx_valid_q <= 1'b1;
                            state_q    <= ST_RD_DATA;
                        end
                    end
                    ST_RD_DATA: begin
                        if (in_rx_valid) begin
                            tx_valid_q <= 1'b0;
                            addr_q     <= addr_inc_d;
                            state_q    <= ST_RD_ISSUE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign o_tx_byte   = tx_byte_q;
    assign o_tx_valid  = tx_valid_q;
    assign o_reg_addr  = reg_addr_q;
    assign o_reg_wdata = wdata_q;
    assign o_reg_we    = we_q;
    assign o_reg_re    = re_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// tb_spi_reg_bridge: directed self-checking bench for spi_reg_bridge
module tb_spi_reg_bridge;
    import spi_reg_bridge_pkg::*;

    logic       clk = 1'b0, rst = 1'b1, cs = 1'b0, rx_valid = 1'b0;
    logic [7:0] rx_byte = 8'h00, rdata = 8'h00;
    logic [7:0] tx_byte, wdata;
    logic [6:0] reg_addr;
    logic       tx_valid, we, re, err;
    int         errors = 0, checks = 0, excl = 0;
    int         wlog[$], rlog[$];

    always #5 clk = ~clk;

    spi_reg_bridge dut (
        .in_clk(clk), .in_rst(rst), .in_cs_active(cs), .in_rx_valid(rx_valid), .in_rx_byte(rx_byte),
        .o_tx_byte(tx_byte), .o_tx_valid(tx_valid), .o_reg_addr(reg_addr), .o_reg_wdata(wdata),
        .o_reg_we(we), .o_reg_re(re), .in_reg_rdata(rdata), .o_err(err)
    );

    always @(posedge clk) if (re) rdata <= {1'b0, reg_addr} ^ 8'hA5;

    always @(negedge clk) begin
        if (we) wlog.push_back(int'({reg_addr, wdata}));
        if (re) rlog.push_back(int'(reg_addr));
        if (we && re) excl++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        tick(6);
    endtask

    task automatic cs_set(input logic v);
        @(negedge clk);
        cs = v;
        tick(2);
    endtask

    task automatic clear_logs();
        wlog.delete();
        rlog.delete();
    endtask

    initial begin
        #1;
        chk("rst_tx_byte", tx_byte, 8'h00);
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_addr", reg_addr, 7'h00);
        chk("rst_we_re_err", {we, re, err}, 3'b000);
        tick(2);
        rst = 1'b0;
        tick(2);

        // write burst
        cs_set(1'b1);
        clear_logs();
        send(8'h05); send(8'hC3); send(8'h5A);
        chk("wr_count", wlog.size(), 2);
        chk("wr_0", wlog.size() > 0 ? wlog[0] : -1, {7'h05, 8'hC3});
        chk("wr_1", wlog.size() > 1 ? wlog[1] : -1, {7'h06, 8'h5A});
        chk("wr_no_re", rlog.size(), 0);
        cs_set(1'b0);

        // read burst with latency
        cs_set(1'b1);
        clear_logs();
        @(negedge clk);
        rx_valid = 1'b1;
        rx_byte  = 8'h85;
        @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
        chk("rd_lat1_valid", tx_valid, 1'b0);
        chk("rd_re_pulse", {re, reg_addr}, {1'b1, 7'h05});
        @(negedge clk);
        chk("rd_lat2_valid", tx_valid, 1'b0);
        chk("rd_re_single", re, 1'b0);
        @(negedge clk);
        chk("rd_lat3_valid", tx_valid, 1'b1);
        chk("rd_tx0", tx_byte, 8'hA0);
        tick(4);
        send(8'h00);
        chk("rd_tx1", tx_byte, 8'hA3);
        chk("rd_tx1_valid", tx_valid, 1'b1);
        chk("rd_re_count", rlog.size(), 2);
        chk("rd_re_addr1", rlog.size() > 1 ? rlog[1] : -1, 7'h06);
        chk("rd_no_we", wlog.size(), 0);
        cs_set(1'b0);
        chk("rd_end_valid", tx_valid, 1'b0);
        chk("rd_end_hold", tx_byte, 8'hA3);

        // address wrap
        cs_set(1'b1);
        clear_logs();
        send(8'h7F); send(8'h11); send(8'h22);
        chk("wrap_0", wlog.size() > 0 ? wlog[0] : -1, {7'h7F, 8'h11});
        chk("wrap_1", wlog.size() > 1 ? wlog[1] : -1, {7'h00, 8'h22});
        chk("wrap_err", err, 1'b0);
        cs_set(1'b0);

        // overrun: second strobe one cycle after the read command
        cs_set(1'b1);
        clear_logs();
        @(negedge clk);
        rx_valid = 1'b1;
        rx_byte  = 8'h85;
        @(negedge clk);
        rx_byte  = 8'hFF;
        @(negedge clk);
        rx_valid = 1'b0;
        tick(6);
        chk("ovr_err", err, 1'b1);
        chk("ovr_re_count", rlog.size(), 1);
        chk("ovr_tx", tx_byte, 8'hA0);
        cs_set(1'b0);
        chk("ovr_err_sticky", err, 1'b1);
        cs_set(1'b1);
        chk("ovr_err_clr", err, 1'b0);
        cs_set(1'b0);

        // abort: CS falls together with the data strobe
        cs_set(1'b1);
        clear_logs();
        send(8'h05);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_byte  = 8'h99;
        cs       = 1'b0;
        @(negedge clk);
        rx_valid = 1'b0;
        tick(4);
        chk("abort_no_we", wlog.size(), 0);
        chk("abort_idle", dut.state_q, ST_IDLE);
        cs_set(1'b1);
        send(8'h05); send(8'h77);
        chk("abort_new_frame", wlog.size() == 1 ? wlog[0] : -1, {7'h05, 8'h77});
        cs_set(1'b0);

        // reset mid read burst, CS held high across release
        cs_set(1'b1);
        clear_logs();
        send(8'h85);
        chk("rstm_tx_pre", tx_byte, 8'hA0);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_byte  = 8'h00;
        @(negedge clk);
        rx_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rstm_tx_byte", tx_byte, 8'h00);
        chk("rstm_addr", reg_addr, 7'h00);
        chk("rstm_wdata", wdata, 8'h00);
        chk("rstm_flags", {tx_valid, we, re, err}, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        clear_logs();
        send(8'h05); send(8'h33); send(8'h85);
        tick(4);
        chk("rstm_no_we", wlog.size(), 0);
        chk("rstm_no_re", rlog.size(), 0);
        cs_set(1'b0);
        cs_set(1'b1);
        send(8'h05); send(8'h44);
        chk("rstm_fresh", wlog.size() == 1 ? wlog[0] : -1, {7'h05, 8'h44});
        cs_set(1'b0);

        chk("we_re_exclusive", excl, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
